fifo_serial_tx: RTL and testbench
=================================

Name: fifo_serial_tx

Overview:
Bit-serial transmitter directly downstream of the bus-side byte FIFO. It pops one word at a time from the FIFO read interface (data, empty, deq). Each word goes out as a framed serial stream: start bit, data LSB-first, optional parity, stop bit. Each bit is held for a fixed number of clock cycles. Back-to-back frames are gapless while the FIFO has data and transmit is enabled.

Parameters:
DATA_WIDTH, 8, width of FIFO word and number of data bits per frame
CLKS_PER_BIT, 4, clock cycles each serial bit is held on tx_out (>=1; 1 must work)

Ports:
clk  input  1  system clock, all logic on rising edge
rstn  input  1  asynchronous active-low reset
tx_en  input  1  transmit enable; sampled only when deciding to start a frame
fifo_empty  input  1  FIFO empty flag
fifo_data  input  DATA_WIDTH  FIFO head word (combinational, valid while !fifo_empty)
fifo_deq  output  1  one-cycle pop strobe to FIFO
tx_out  output  1  serial line, idle high, registered
tx_busy  output  1  high while a frame is in progress (any state except IDLE)
tx_done  output  1  one-cycle pulse on the last cycle of the stop bit

Behaviour:
- Reset (async, rstn low): state=IDLE, tx_out=1, fifo_deq=0, tx_busy=0, tx_done=0, bit/cycle counters=0, shift register=0.
- Reset mid-frame aborts immediately. tx_out returns high with no partial stop bit. The popped word is lost.
- fifo_deq is combinational from state: asserted iff (IDLE, or last cycle of STOP) AND tx_en AND !fifo_empty.
- On a fifo_deq cycle, fifo_data is latched into the shift register in the same edge, and state goes to START.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE or START.
- START: tx_out=0 for CLKS_PER_BIT cycles.
- DATA: DATA_WIDTH bits, LSB first, each held CLKS_PER_BIT cycles. The shift register shifts right at each bit boundary.
- STOP: tx_out=1 for CLKS_PER_BIT cycles. tx_done=1 on the last STOP cycle.
- STOP exit: goes to START when fifo_deq fires, else to IDLE.
- tx_out is registered: the first start-bit cycle is the cycle after the fifo_deq cycle.
- Frame length is (DATA_WIDTH+2)*CLKS_PER_BIT cycles, or +CLKS_PER_BIT with parity.
- Back-to-back frames: no idle cycle between the stop bit of frame N and the start bit of frame N+1.
- Cycle counter counts 0..CLKS_PER_BIT-1 and wraps at each bit boundary. With CLKS_PER_BIT=1 every cycle is a boundary.
- Bit counter counts 0..DATA_WIDTH-1 within DATA.
- tx_en deassert mid-frame: the current frame completes normally, and no further pop occurs.
- fifo_empty asserting mid-frame has no effect on the current frame.
- fifo_deq is never asserted when fifo_empty=1 or state is not IDLE/last-STOP. At most one pop per frame.
- tx_busy=1 in START/DATA/PARITY/STOP, including the last STOP cycle even if returning to IDLE.

Optional Feature:
Macro SERIAL_TX_PARITY_EN.
- Defined: PARITY state is inserted after DATA for CLKS_PER_BIT cycles. tx_out = XOR of all data bits (even parity). Frame length is (DATA_WIDTH+3)*CLKS_PER_BIT.
- Not defined: no PARITY state and no parity logic. DATA goes directly to STOP.

Test Plan:
- Single word (DATA_WIDTH=8, CLKS_PER_BIT=4): FIFO holds 0xA5, tx_en=1.
  - fifo_deq pulses exactly 1 cycle.
  - tx_out, next 40 cycles, 4 cycles each: 0,1,0,1,0,0,1,0,1,1.
  - tx_done pulses on cycle 40, then tx_out=1 and tx_busy=0.
- Back-to-back: FIFO holds 0x01 then 0x80.
  - Two fifo_deq pulses, 40 cycles apart.
  - 80 contiguous frame cycles with no idle gap; tx_done pulses at cycles 40 and 80.
- Empty/disable: fifo_empty=1 with tx_en=1, and separately data present with tx_en=0 for 100 cycles.
  - fifo_deq never asserts, tx_out stays 1, tx_busy stays 0.
- Mid-frame disable and reset:
  - tx_en dropped during DATA of 0x3C: frame completes with stop bit, no second pop although FIFO is non-empty.
  - rstn pulsed low during DATA: tx_out=1 and tx_busy=0 asynchronously; after release, the next word starts only after a fresh fifo_deq.
- CLKS_PER_BIT=1: word 0xFF gives tx_out 0,1,1,1,1,1,1,1,1,1, one cycle each, 10-cycle frame.
- With SERIAL_TX_PARITY_EN:
  - 0xA5 gives parity bit 0 and a 44-cycle frame.
  - 0x07 gives parity bit 1 and a 44-cycle frame.

Source files
------------

// File: rtl/fifo_serial_tx.sv
// fifo_serial_tx: pops words from the upstream byte FIFO and sends each one as a
// serial frame: start bit, data bits LSB first, optional parity bit, stop bit.
// Each bit is held on tx_out for CLKS_PER_BIT clocks.
// Frames follow each other with no gap while the FIFO has data and tx_en is high.
// Optional feature macro: SERIAL_TX_PARITY_EN.
// When it is defined, an even-parity bit is inserted between DATA and STOP.
module fifo_serial_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  tx_en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_deq,
  output logic                  tx_out,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef SERIAL_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cycCnt;
  logic [BW-1:0]         r_bitCnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_txOut;
`ifdef SERIAL_TX_PARITY_EN
  logic                  r_parity;
`endif

  state_t                w_nextState;
  logic [CW-1:0]         w_nextCyc;
  logic [BW-1:0]         w_nextBit;
  logic [DATA_WIDTH-1:0] w_nextShift;
  logic                  w_nextTx;
  logic                  w_deq;
  logic                  w_done;
  logic                  w_canPop;
  logic                  w_bitEnd;

  // A pop is only legal outside reset, so the FIFO is never drained while rstn is held low.
  assign w_canPop = rstn & tx_en & ~fifo_empty;
  assign w_bitEnd = (r_cycCnt == CYC_LAST);

  assign fifo_deq = w_deq;
  assign tx_out   = r_txOut;
  assign tx_busy  = (r_state != S_IDLE);
  assign tx_done  = w_done;

  // Next-state, counter and shift logic.
  // tx_out is computed from the next state and next shift value so that the register lines up with the state.
  always_comb begin
    w_nextState = r_state;
    w_nextCyc   = r_cycCnt;
    w_nextBit   = r_bitCnt;
    w_nextShift = r_shift;
    w_deq       = 1'b0;
    w_done      = 1'b0;
    w_nextTx    = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (w_canPop) begin
          w_deq       = 1'b1;
          w_nextShift = fifo_data;
          w_nextState = S_START;
          w_nextCyc   = '0;
          w_nextBit   = '0;
        end
      end
      S_START: begin
        if (w_bitEnd) begin
          w_nextCyc   = '0;
          w_nextBit   = '0;
          w_nextState = S_DATA;
        end else begin
          w_nextCyc = r_cycCnt + CW'(1);
        end
      end
      S_DATA: begin
        if (w_bitEnd) begin
          w_nextCyc   = '0;
          w_nextShift = r_shift >> 1;
          if (r_bitCnt == BIT_LAST) begin
            w_nextBit = '0;
`ifdef SERIAL_TX_PARITY_EN
            w_nextState = S_PARITY;
`else
            w_nextState = S_STOP;
`endif
          end else begin
            w_nextBit = r_bitCnt + BW'(1);
          end
        end else begin
          w_nextCyc = r_cycCnt + CW'(1);
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: begin
        if (w_bitEnd) begin
          w_nextCyc   = '0;
          w_nextState = S_STOP;
        end else begin
          w_nextCyc = r_cycCnt + CW'(1);
        end
      end
`endif
      S_STOP: begin
        if (w_bitEnd) begin
          w_done    = 1'b1;
          w_nextCyc = '0;
          if (w_canPop) begin
            w_deq       = 1'b1;
            w_nextShift = fifo_data;
            w_nextBit   = '0;
            w_nextState = S_START;
          end else begin
            w_nextState = S_IDLE;
          end
        end else begin
          w_nextCyc = r_cycCnt + CW'(1);
        end
      end
      default: w_nextState = S_IDLE;
    endcase
    case (w_nextState)
      S_START:  w_nextTx = 1'b0;
      S_DATA:   w_nextTx = w_nextShift[0];
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: w_nextTx = r_parity;
`endif
      default:  w_nextTx = 1'b1;
    endcase
  end

  // State, counters, shift register and line register.
  // Reset drops any frame in flight and returns the line high at once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_cycCnt <= '0;
      r_bitCnt <= '0;
      r_shift  <= '0;
      r_txOut  <= 1'b1;
    end else begin
      r_state  <= w_nextState;
      r_cycCnt <= w_nextCyc;
      r_bitCnt <= w_nextBit;
      r_shift  <= w_nextShift;
      r_txOut  <= w_nextTx;
    end
  end

`ifdef SERIAL_TX_PARITY_EN
  // Even parity of the whole word, captured when the word is popped because the shift register is consumed later.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_parity <= 1'b0;
    end else if (w_deq) begin
      r_parity <= ^fifo_data;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_serial_tx.sv
// tb_fifo_serial_tx: directed bench for fifo_serial_tx.
// Instance u_dut uses CLKS_PER_BIT=4 and is fed by a small FIFO inside the bench.
// Instance u_dut1 uses CLKS_PER_BIT=1 and is fed by a constant word.
module tb_fifo_serial_tx;

  localparam int DW  = 8;
  localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int NB = DW + 3;
`else
  localparam int NB = DW + 2;
`endif

  typedef struct {
    string      name;
    logic [7:0] word;
    logic [9:0] ser;
    logic       par;
  } vec_t;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic       txEn = 1'b0;
  logic [7:0] fifoMem [0:15];
  logic [7:0] rdPtr = '0;
  logic [7:0] wrPtr = '0;
  logic       fifoEmpty;
  logic [7:0] fifoData;
  logic       deq, txOut, busy, done;

  logic       en1    = 1'b0;
  logic       empty1 = 1'b1;
  logic [7:0] data1  = 8'hFF;
  logic       deq1, tx1, busy1, done1;

  int errors = 0;
  int checks = 0;

  assign fifoEmpty = (rdPtr == wrPtr);
  assign fifoData  = fifoMem[rdPtr[3:0]];

  fifo_serial_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) u_dut (
    .clk(clk), .rstn(rstn), .tx_en(txEn), .fifo_empty(fifoEmpty), .fifo_data(fifoData),
    .fifo_deq(deq), .tx_out(txOut), .tx_busy(busy), .tx_done(done));

  fifo_serial_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .tx_en(en1), .fifo_empty(empty1), .fifo_data(data1),
    .fifo_deq(deq1), .tx_out(tx1), .tx_busy(busy1), .tx_done(done1));

  // Free-running 100 MHz-style clock.
  always #5 clk = ~clk;

  // The bench FIFO advances its read pointer whenever the DUT pops.
  always @(posedge clk) begin
    if (deq) rdPtr <= rdPtr + 8'd1;
  end

  // Watchdog so a stuck run still ends.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic en, input logic rst);
    txEn = en;
    rstn = rst;
    #1;
  endtask

  task automatic pushWord(input logic [7:0] w);
    fifoMem[wrPtr[3:0]] = w;
    wrPtr = wrPtr + 8'd1;
    #1;
  endtask

  task automatic cmpBit(input string name, input string sig, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s.%s got=%b exp=%b at %0t", name, sig, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string name, input logic aDeq, input logic aTx, input logic aBusy,
                             input logic aDone, input logic eDeq, input logic eTx, input logic eBusy,
                             input logic eDone);
    cmpBit(name, "deq", aDeq, eDeq);
    cmpBit(name, "tx", aTx, eTx);
    cmpBit(name, "busy", aBusy, eBusy);
    cmpBit(name, "done", aDone, eDone);
  endtask

  // Expected line level at bit position pos of a frame.
  // ser holds {stop, data, start}; the parity bit is only present when the feature is built in.
  function automatic logic expBit(input logic [9:0] ser, input logic par, input int pos);
    if (pos <= DW) return ser[pos];
    if (pos == NB - 1) return ser[9];
    return par;
  endfunction

  task automatic waitDeq(input string name, input int maxCycles);
    for (int i = 0; i < maxCycles && !deq; i++) step();
    checks++;
    if (!deq) begin
      errors++;
      $display("[TB] FAIL %s.waitDeq got=0 exp=1 (timeout)", name);
    end
  endtask

  // Checks frame cycles 1..NB*CPB of the main DUT, starting from the pop cycle.
  task automatic checkFrame(input string name, input logic [9:0] ser, input logic par,
                            input logic expNextDeq, input int dropAt);
    int f;
    f = NB * CPB;
    for (int k = 1; k <= f; k++) begin
      step();
      if (k == dropAt) applyStimulus(1'b0, 1'b1);
      checkOutput(name, deq, txOut, busy, done,
                  (k == f) && expNextDeq, expBit(ser, par, (k - 1) / CPB), 1'b1, (k == f));
    end
  endtask

  task automatic idleCycles(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      checkOutput(name, deq, txOut, busy, done, 1'b0, 1'b1, 1'b0, 1'b0);
    end
  endtask

  initial begin
    vec_t vecs[5];
    vecs[0] = '{"a5", 8'hA5, 10'b1101001010, 1'b0};
    vecs[1] = '{"07", 8'h07, 10'b1000001110, 1'b1};
    vecs[2] = '{"00", 8'h00, 10'b1000000000, 1'b0};
    vecs[3] = '{"ff", 8'hFF, 10'b1111111110, 1'b0};
    vecs[4] = '{"80", 8'h80, 10'b1100000000, 1'b1};

    // Reset values.
    step();
    step();
    checkOutput("reset", deq, txOut, busy, done, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("reset1", deq1, tx1, busy1, done1, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);

    // Empty FIFO with transmit enabled.
    applyStimulus(1'b1, 1'b1);
    idleCycles("empty", 100);

    // Data present but transmit disabled.
    applyStimulus(1'b0, 1'b1);
    pushWord(8'hA5);
    idleCycles("disabled", 100);

    // Single frames from the table; the first word is already waiting in the FIFO.
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) pushWord(vecs[i].word);
      waitDeq(vecs[i].name, 5);
      checkOutput(vecs[i].name, deq, txOut, busy, done, 1'b1, 1'b1, 1'b0, 1'b0);
      checkFrame(vecs[i].name, vecs[i].ser, vecs[i].par, 1'b0, 0);
      idleCycles(vecs[i].name, 1);
    end

    // Back-to-back frames with no gap.
    applyStimulus(1'b0, 1'b1);
    pushWord(8'h01);
    pushWord(8'h80);
    applyStimulus(1'b1, 1'b1);
    waitDeq("b2b", 5);
    checkOutput("b2b", deq, txOut, busy, done, 1'b1, 1'b1, 1'b0, 1'b0);
    checkFrame("b2b_01", 10'b1000000010, 1'b1, 1'b1, 0);
    checkFrame("b2b_80", 10'b1100000000, 1'b1, 1'b0, 0);
    idleCycles("b2b_end", 2);

    // tx_en dropped during DATA: the frame completes and nothing more is popped.
    applyStimulus(1'b0, 1'b1);
    pushWord(8'h3C);
    pushWord(8'h55);
    applyStimulus(1'b1, 1'b1);
    waitDeq("drop", 5);
    checkOutput("drop", deq, txOut, busy, done, 1'b1, 1'b1, 1'b0, 1'b0);
    checkFrame("drop_3c", 10'b1001111000, 1'b0, 1'b0, 12);
    idleCycles("drop_idle", 20);

    // Reset mid-frame: 0x55 is popped and then lost.
    applyStimulus(1'b1, 1'b1);
    waitDeq("rst", 5);
    checkOutput("rst", deq, txOut, busy, done, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step();
    checkOutput("rst_pre", deq, txOut, busy, done, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("rst_async", deq, txOut, busy, done, 1'b0, 1'b1, 1'b0, 1'b0);
    pushWord(8'hC3);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("rst_hold", deq, txOut, busy, done, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 1'b1);
    idleCycles("rst_release", 5);
    applyStimulus(1'b1, 1'b1);
    waitDeq("rst_c3", 5);
    checkOutput("rst_c3", deq, txOut, busy, done, 1'b1, 1'b1, 1'b0, 1'b0);
    checkFrame("rst_c3", 10'b1110000110, 1'b0, 1'b0, 0);
    idleCycles("rst_c3_end", 2);

    // CLKS_PER_BIT=1: every cycle is a bit boundary.
    en1    = 1'b1;
    empty1 = 1'b0;
    #1;
    checkOutput("cpb1", deq1, tx1, busy1, done1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= NB; k++) begin
      step();
      empty1 = 1'b1;
      #1;
      checkOutput("cpb1", deq1, tx1, busy1, done1, 1'b0,
                  expBit(10'b1111111110, 1'b0, k - 1), 1'b1, (k == NB));
    end
    step();
    checkOutput("cpb1_end", deq1, tx1, busy1, done1, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
